// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: opcodes, FSM states,
// ALU/mux select codes and the control word driven into the datapath.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EX     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ORI_EX   = 4'd10,
        S_ORI_WB   = 4'd11
    } state_e;

    localparam logic [1:0] ALUOP_SUB   = 2'b00;
    localparam logic [1:0] ALUOP_ADD   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       memto_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       ext_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outputs.sv
// Combinational decode of the current FSM state into the datapath control word.
module mc_ctrl_outputs
    import mc_ctrl_pkg::*;
(
    input  logic   rst_n,
    input  state_e state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl        = '0;
        ctrl.ext_op = 1'b1;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.memto_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_R_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ORI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.ext_op    = 1'b0;
                ctrl.alu_op    = ALUOP_OR;
            end
            S_ORI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: begin
            end
        endcase
        // Reset overrides everything, including the mem_ready-gated fetch strobes.
        if (!rst_n) begin
            ctrl = '0;
        end
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle MIPS datapath: instruction sequencing,
// retire/illegal-op pulses and the retired-instruction counter.
module multicycle_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Op,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ExtOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALU_op,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [3:0]       state_dbg
);

    state_e           state_q, state_d;
    logic             instr_done_q, instr_done_d;
    logic             illegal_op_q, illegal_op_d;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
    logic             retire;
    logic             illegal;
    ctrl_t            ctrl;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        illegal = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_R_EX;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ORI:       state_d = S_ORI_EX;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (Op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_R_EX:   state_d = S_R_WB;
            S_ORI_EX: state_d = S_ORI_WB;
            S_MEM_WB, S_R_WB, S_ORI_WB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        instr_done_d  = retire;
        illegal_op_d  = illegal;
        retired_cnt_d = retired_cnt_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            instr_done_q  <= 1'b0;
            illegal_op_q  <= 1'b0;
            retired_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_done_q  <= instr_done_d;
            illegal_op_q  <= illegal_op_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    mc_ctrl_outputs u_outputs (
        .rst_n     (rst_n),
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.memto_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ExtOp       = ctrl.ext_op;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;
    assign ALU_op      = ctrl.alu_op;
    assign instr_done  = instr_done_q;
    assign illegal_op  = illegal_op_q;
    assign retired_cnt = retired_cnt_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: one step per clock, every
// expected control word written out by hand from the state table.
module tb_multicycle_main_control;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    // Flags: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ExtOp ALUSrcA
    localparam logic [16:0] CW_RESET      = '0;
    localparam logic [16:0] CW_FETCH_RDY  = {11'b1_0_0_1_0_1_0_0_0_1_0, 2'b01, 2'b00, 2'b01};
    localparam logic [16:0] CW_FETCH_WAIT = {11'b0_0_0_1_0_0_0_0_0_1_0, 2'b01, 2'b00, 2'b01};
    localparam logic [16:0] CW_DECODE     = {11'b0_0_0_0_0_0_0_0_0_1_0, 2'b11, 2'b00, 2'b01};
    localparam logic [16:0] CW_MEM_ADDR   = {11'b0_0_0_0_0_0_0_0_0_1_1, 2'b10, 2'b00, 2'b01};
    localparam logic [16:0] CW_MEM_RD     = {11'b0_0_1_1_0_0_0_0_0_1_0, 2'b00, 2'b00, 2'b00};
    localparam logic [16:0] CW_MEM_WB     = {11'b0_0_0_0_0_0_1_0_1_1_0, 2'b00, 2'b00, 2'b00};
    localparam logic [16:0] CW_MEM_WR     = {11'b0_0_1_0_1_0_0_0_0_1_0, 2'b00, 2'b00, 2'b00};
    localparam logic [16:0] CW_R_EX       = {11'b0_0_0_0_0_0_0_0_0_1_1, 2'b00, 2'b00, 2'b10};
    localparam logic [16:0] CW_R_WB       = {11'b0_0_0_0_0_0_0_1_1_1_0, 2'b00, 2'b00, 2'b00};
    localparam logic [16:0] CW_BRANCH     = {11'b0_1_0_0_0_0_0_0_0_1_1, 2'b00, 2'b01, 2'b00};
    localparam logic [16:0] CW_JUMP       = {11'b1_0_0_0_0_0_0_0_0_1_0, 2'b00, 2'b10, 2'b00};
    localparam logic [16:0] CW_ORI_EX     = {11'b0_0_0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 2'b11};
    localparam logic [16:0] CW_ORI_WB     = {11'b0_0_0_0_0_0_0_0_1_1_0, 2'b00, 2'b00, 2'b00};

    logic       clk;
    logic       rst_n;
    logic [5:0] Op;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ExtOp, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource, ALU_op;
    logic       instr_done, illegal_op;
    logic [3:0] retired_cnt;
    logic [3:0] state_dbg;
    logic [16:0] cw;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_main_control #(.CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Op          (Op),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ExtOp       (ExtOp),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .ALU_op      (ALU_op),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .retired_cnt (retired_cnt),
        .state_dbg   (state_dbg)
    );

    assign cw = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 RegDst, RegWrite, ExtOp, ALUSrcA, ALUSrcB, PCSource, ALU_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic step(input logic r, input logic [5:0] op, input logic mr,
                        input logic [3:0] es, input logic [16:0] ecw, input string tag);
        @(negedge clk);
        rst_n     = r;
        Op        = op;
        mem_ready = mr;
        #1;
        chk({tag, "_state"}, 32'(state_dbg), 32'(es));
        chk({tag, "_ctrl"}, 32'(cw), 32'(ecw));
    endtask

    task automatic pulses(input string tag, input logic done, input logic ill, input logic [3:0] cnt);
        chk({tag, "_done"}, 32'(instr_done), 32'(done));
        chk({tag, "_illegal"}, 32'(illegal_op), 32'(ill));
        chk({tag, "_cnt"}, 32'(retired_cnt), 32'(cnt));
    endtask

    initial begin
        rst_n     = 1'b0;
        Op        = OP_R;
        mem_ready = 1'b1;

        step(0, OP_R, 1, 4'd0, CW_RESET, "rst1");
        pulses("rst1", 0, 0, 4'd0);
        step(0, OP_R, 1, 4'd0, CW_RESET, "rst2");

        // R-type: 0,1,6,7,0
        step(1, OP_R, 1, 4'd0, CW_FETCH_RDY, "r_fetch");
        pulses("r_fetch", 0, 0, 4'd0);
        step(1, OP_R, 1, 4'd1, CW_DECODE, "r_decode");
        step(1, OP_R, 1, 4'd6, CW_R_EX, "r_ex");
        step(1, OP_R, 1, 4'd7, CW_R_WB, "r_wb");
        pulses("r_wb", 0, 0, 4'd0);

        // lw with three wait cycles in MEM_RD
        step(1, OP_LW, 1, 4'd0, CW_FETCH_RDY, "lw_fetch");
        pulses("r_retire", 1, 0, 4'd1);
        step(1, OP_LW, 1, 4'd1, CW_DECODE, "lw_decode");
        pulses("lw_decode", 0, 0, 4'd1);
        step(1, OP_LW, 1, 4'd2, CW_MEM_ADDR, "lw_addr");
        step(1, OP_LW, 0, 4'd3, CW_MEM_RD, "lw_wait1");
        step(1, OP_LW, 0, 4'd3, CW_MEM_RD, "lw_wait2");
        step(1, OP_LW, 0, 4'd3, CW_MEM_RD, "lw_wait3");
        step(1, OP_LW, 1, 4'd3, CW_MEM_RD, "lw_rd");
        step(1, OP_LW, 1, 4'd4, CW_MEM_WB, "lw_wb");
        pulses("lw_wb", 0, 0, 4'd1);

        // beq then ori
        step(1, OP_BEQ, 1, 4'd0, CW_FETCH_RDY, "beq_fetch");
        pulses("lw_retire", 1, 0, 4'd2);
        step(1, OP_BEQ, 1, 4'd1, CW_DECODE, "beq_decode");
        step(1, OP_BEQ, 1, 4'd8, CW_BRANCH, "beq_branch");
        step(1, OP_ORI, 1, 4'd0, CW_FETCH_RDY, "ori_fetch");
        pulses("beq_retire", 1, 0, 4'd3);
        step(1, OP_ORI, 1, 4'd1, CW_DECODE, "ori_decode");
        step(1, OP_ORI, 1, 4'd10, CW_ORI_EX, "ori_ex");
        step(1, OP_ORI, 1, 4'd11, CW_ORI_WB, "ori_wb");

        // Unknown opcode: back to FETCH, illegal pulse only
        step(1, OP_BAD, 1, 4'd0, CW_FETCH_RDY, "bad_fetch");
        pulses("ori_retire", 1, 0, 4'd4);
        step(1, OP_BAD, 1, 4'd1, CW_DECODE, "bad_decode");
        pulses("bad_decode", 0, 0, 4'd4);
        step(1, OP_BAD, 0, 4'd0, CW_FETCH_WAIT, "bad_after1");
        pulses("bad_after1", 0, 1, 4'd4);
        step(1, OP_BAD, 0, 4'd0, CW_FETCH_WAIT, "bad_after2");
        pulses("bad_after2", 0, 0, 4'd4);

        // sw completing normally
        step(1, OP_SW, 1, 4'd0, CW_FETCH_RDY, "sw_fetch");
        step(1, OP_SW, 1, 4'd1, CW_DECODE, "sw_decode");
        step(1, OP_SW, 1, 4'd2, CW_MEM_ADDR, "sw_addr");
        step(1, OP_SW, 1, 4'd5, CW_MEM_WR, "sw_wr");
        pulses("sw_wr", 0, 0, 4'd4);
        step(1, OP_SW, 1, 4'd0, CW_FETCH_RDY, "sw2_fetch");
        pulses("sw_retire", 1, 0, 4'd5);

        // sw interrupted by reset during the MEM_WR wait
        step(1, OP_SW, 1, 4'd1, CW_DECODE, "sw2_decode");
        step(1, OP_SW, 1, 4'd2, CW_MEM_ADDR, "sw2_addr");
        step(1, OP_SW, 0, 4'd5, CW_MEM_WR, "sw2_wait1");
        step(1, OP_SW, 0, 4'd5, CW_MEM_WR, "sw2_wait2");
        step(0, OP_SW, 0, 4'd5, CW_RESET, "sw2_rst_in");
        step(0, OP_SW, 0, 4'd0, CW_RESET, "sw2_rst_after");
        pulses("sw2_rst_after", 0, 0, 4'd0);

        // 16 jumps on a 4-bit counter wrap it back to zero
        for (int i = 0; i < 16; i++) begin
            step(1, OP_J, 1, 4'd0, CW_FETCH_RDY, "j_fetch");
            pulses("j_fetch", (i > 0), 0, 4'(i));
            step(1, OP_J, 1, 4'd1, CW_DECODE, "j_decode");
            step(1, OP_J, 1, 4'd9, CW_JUMP, "j_jump");
        end
        step(1, OP_R, 1, 4'd0, CW_FETCH_RDY, "j_wrap_fetch");
        pulses("j_wrap", 1, 0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
